// File: rtl/adder_axis_pkg.sv
// Shared types and helpers for the AXI-Stream adder and its downstream accumulator.
package adder_axis_pkg;

   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } acc_state_t;

   // AXI-Stream tdata must be a whole number of bytes.
   function automatic int axis_width(input int w);
      return ((w + 7) / 8) * 8;
   endfunction

endpackage

// File: rtl/adder_axis_acc_if.sv
// Input and output AXI-Stream channels of the accumulator.
// ADDER_AXIS_ACC_TLAST_EN adds data_i_tlast/data_o_tlast to both modports.
interface adder_axis_acc_if #(
   parameter int IN_AXIS_WIDTH  = 8,
   parameter int OUT_AXIS_WIDTH = 8
);

   logic [IN_AXIS_WIDTH-1:0]  data_i_tdata;
   logic                      data_i_tvalid;
   logic                      data_i_tready;
   logic [OUT_AXIS_WIDTH-1:0] data_o_tdata;
   logic                      data_o_tvalid;
   logic                      data_o_tready;

`ifdef ADDER_AXIS_ACC_TLAST_EN
   logic                      data_i_tlast;
   logic                      data_o_tlast;

   modport slave (
      input  data_i_tdata, data_i_tvalid, data_i_tlast, data_o_tready,
      output data_i_tready, data_o_tdata, data_o_tvalid, data_o_tlast
   );

   modport master (
      output data_i_tdata, data_i_tvalid, data_i_tlast, data_o_tready,
      input  data_i_tready, data_o_tdata, data_o_tvalid, data_o_tlast
   );
`else
   modport slave (
      input  data_i_tdata, data_i_tvalid, data_o_tready,
      output data_i_tready, data_o_tdata, data_o_tvalid
   );

   modport master (
      output data_i_tdata, data_i_tvalid, data_o_tready,
      input  data_i_tready, data_o_tdata, data_o_tvalid
   );
`endif

endinterface

// File: rtl/adder_axis_acc_cu.sv
// Control unit of the accumulator: ACCUM/OUTPUT FSM, beat counter, handshake
// signals and load strobes for the datapath registers in the top module.
module adder_axis_acc_cu
   import adder_axis_pkg::*;
#(
   parameter int ACC_LEN = 4
) (
   input  logic aclk,
   input  logic aresetn,
   input  logic in_valid,
   input  logic in_last,
   input  logic out_ready,
   output logic in_ready,
   output logic out_valid,
   output logic acc_ce,
   output logic acc_clr,
   output logic out_ce
);

   localparam int CNT_WIDTH = $clog2(ACC_LEN);
   localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(ACC_LEN - 1);

   acc_state_t           state;
   acc_state_t           next_state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 ready_q;
   logic                 in_hs;
   logic                 frame_end;

   assign in_hs     = in_valid & ready_q;
   assign frame_end = in_hs & ((cnt == CNT_LAST) | in_last);

   // ready_q is registered so it reads 0 during reset and only rises once
   // the FSM is actually able to take a beat.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state   <= ACCUM;
         ready_q <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= next_state;
         ready_q <= (next_state == ACCUM);
         if (frame_end)
            cnt <= '0;
         else if (in_hs)
            cnt <= cnt + 1'b1;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ACCUM:   if (frame_end) next_state = OUTPUT;
         OUTPUT:  if (out_ready) next_state = ACCUM;
         default: next_state = ACCUM;
      endcase
   end

   always_comb begin
      in_ready  = ready_q;
      out_valid = (state == OUTPUT);
      acc_ce    = in_hs;
      acc_clr   = frame_end;
      out_ce    = frame_end;
   end

endmodule

// File: rtl/adder_axis_acc.sv
// AXI-Stream accumulator: sums ACC_LEN input beats into one output beat.
// Optional early frame close on tlast with ADDER_AXIS_ACC_TLAST_EN.
module adder_axis_acc
   import adder_axis_pkg::*;
#(
   parameter int DATA_WIDTH     = 5,
   parameter int ACC_LEN        = 4,
   parameter int ACC_WIDTH      = DATA_WIDTH + $clog2(ACC_LEN),
   parameter int IN_AXIS_WIDTH  = axis_width(DATA_WIDTH),
   parameter int OUT_AXIS_WIDTH = axis_width(ACC_WIDTH)
) (
   input logic             aclk,
   input logic             aresetn,
   adder_axis_acc_if.slave axis
);

   logic [ACC_WIDTH-1:0] acc;
   logic [ACC_WIDTH-1:0] out_data;
   logic [ACC_WIDTH-1:0] sum_next;
   logic                 in_last;
   logic                 out_valid;
   logic                 acc_ce;
   logic                 acc_clr;
   logic                 out_ce;

   generate
      if (IN_AXIS_WIDTH > DATA_WIDTH) begin : g_pad
         logic unused_hi;
         assign unused_hi = ^axis.data_i_tdata[IN_AXIS_WIDTH-1:DATA_WIDTH];
      end
   endgenerate

`ifdef ADDER_AXIS_ACC_TLAST_EN
   assign in_last           = axis.data_i_tlast;
   assign axis.data_o_tlast = out_valid;
`else
   assign in_last = 1'b0;
`endif

   assign sum_next = acc + ACC_WIDTH'(axis.data_i_tdata[DATA_WIDTH-1:0]);

   adder_axis_acc_cu #(
      .ACC_LEN (ACC_LEN)
   ) u_cu (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .in_valid  (axis.data_i_tvalid),
      .in_last   (in_last),
      .out_ready (axis.data_o_tready),
      .in_ready  (axis.data_i_tready),
      .out_valid (out_valid),
      .acc_ce    (acc_ce),
      .acc_clr   (acc_clr),
      .out_ce    (out_ce)
   );

   // The closing beat goes straight into the output register, so the
   // accumulator itself restarts from zero on the same edge.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc      <= '0;
         out_data <= '0;
      end else begin
         if (acc_clr)
            acc <= '0;
         else if (acc_ce)
            acc <= sum_next;
         if (out_ce)
            out_data <= sum_next;
      end
   end

   assign axis.data_o_tdata  = OUT_AXIS_WIDTH'(out_data);
   assign axis.data_o_tvalid = out_valid;

endmodule

// File: tb/tb_adder_axis_acc.sv
// Self-checking bench for adder_axis_acc: directed frames plus random frames
// against a frame-sum reference model.
module tb_adder_axis_acc;

   localparam int DATA_WIDTH = 5;
   localparam int ACC_LEN    = 4;
   localparam int IN_W       = 8;
   localparam int OUT_W      = 8;

   logic aclk    = 1'b0;
   logic aresetn = 1'b0;
   int   compared   = 0;
   int   mismatched = 0;
   int   frame_q[$];

   adder_axis_acc_if #(.IN_AXIS_WIDTH(IN_W), .OUT_AXIS_WIDTH(OUT_W)) axis ();

   adder_axis_acc #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_LEN    (ACC_LEN)
   ) dut (
      .aclk    (aclk),
      .aresetn (aresetn),
      .axis    (axis.slave)
   );

   always #5 aclk = ~aclk;

   function automatic int modelTotal();
      int total = 0;
      foreach (frame_q[i]) total += frame_q[i] % (1 << DATA_WIDTH);
      return total;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic setLast(input logic last);
`ifdef ADDER_AXIS_ACC_TLAST_EN
      axis.data_i_tlast = last;
`else
      if (last) axis.data_i_tvalid = axis.data_i_tvalid;
`endif
   endtask

   // Entered and left on a falling edge; one accepted beat per call.
   task automatic applyStimulus(input int d, input logic last, input int gap);
      int waited = 0;
      repeat (gap) @(negedge aclk);
      axis.data_i_tdata  = IN_W'(d);
      axis.data_i_tvalid = 1'b1;
      setLast(last);
      while (axis.data_i_tready !== 1'b1 && waited < 64) begin
         @(negedge aclk);
         waited++;
      end
      checkOutput("in_ready_wait", 32'(axis.data_i_tready), 1);
      checkOutput("out_valid_accum", 32'(axis.data_o_tvalid), 0);
      @(posedge aclk);
      @(negedge aclk);
      axis.data_i_tvalid = 1'b0;
      axis.data_i_tdata  = IN_W'($urandom);
      setLast(1'b0);
   endtask

   task automatic sendFrame(input int max_gap, input logic last_at_end);
      foreach (frame_q[i])
         applyStimulus(frame_q[i], last_at_end && (i == frame_q.size() - 1),
                       $urandom_range(max_gap, 0));
   endtask

   task automatic expectTotal(input int exp, input int stall);
      checkOutput("out_valid_latency", 32'(axis.data_o_tvalid), 1);
      checkOutput("out_data", 32'(axis.data_o_tdata), exp);
      checkOutput("in_ready_in_output", 32'(axis.data_i_tready), 0);
`ifdef ADDER_AXIS_ACC_TLAST_EN
      checkOutput("out_tlast", 32'(axis.data_o_tlast), 1);
`endif
      if (stall > 0) begin
         axis.data_o_tready = 1'b0;
         for (int i = 0; i < stall; i++) begin
            @(negedge aclk);
            checkOutput("stall_valid", 32'(axis.data_o_tvalid), 1);
            checkOutput("stall_data", 32'(axis.data_o_tdata), exp);
            checkOutput("stall_in_ready", 32'(axis.data_i_tready), 0);
         end
      end
      axis.data_o_tready = 1'b1;
      @(posedge aclk);
      @(negedge aclk);
      checkOutput("valid_after_hs", 32'(axis.data_o_tvalid), 0);
      checkOutput("data_held", 32'(axis.data_o_tdata), exp);
      checkOutput("in_ready_after_hs", 32'(axis.data_i_tready), 1);
`ifdef ADDER_AXIS_ACC_TLAST_EN
      checkOutput("tlast_after_hs", 32'(axis.data_o_tlast), 0);
`endif
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_tdata"}, 32'(axis.data_o_tdata), 0);
      checkOutput({tag, "_tvalid"}, 32'(axis.data_o_tvalid), 0);
      checkOutput({tag, "_tready"}, 32'(axis.data_i_tready), 0);
`ifdef ADDER_AXIS_ACC_TLAST_EN
      checkOutput({tag, "_tlast"}, 32'(axis.data_o_tlast), 0);
`endif
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int len;
      logic early;
      axis.data_i_tdata  = '0;
      axis.data_i_tvalid = 1'b0;
      axis.data_o_tready = 1'b1;
      setLast(1'b0);

      repeat (2) @(negedge aclk);
      checkResetOutputs("reset");
      #2 aresetn = 1'b1;
      @(negedge aclk);

      frame_q = {1, 2, 3, 4};
      sendFrame(0, 1'b0);
      expectTotal(10, 0);

      frame_q = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      sendFrame(0, 1'b0);
      expectTotal(124, 0);

      frame_q = {5, 6, 7, 8};
      sendFrame(0, 1'b0);
      expectTotal(26, 5);

      frame_q = {1, 1, 1, 1};
      sendFrame(4, 1'b0);
      expectTotal(modelTotal(), 0);
      frame_q = {2, 2, 2, 2};
      sendFrame(4, 1'b0);
      expectTotal(modelTotal(), 0);

      applyStimulus(9, 1'b0, 0);
      applyStimulus(9, 1'b0, 0);
      #2 aresetn = 1'b0;
      #1 checkResetOutputs("mid_reset");
      @(negedge aclk);
      checkResetOutputs("mid_reset_hold");
      #2 aresetn = 1'b1;
      @(negedge aclk);
      frame_q = {5, 5, 5, 5};
      sendFrame(0, 1'b0);
      expectTotal(20, 0);

`ifdef ADDER_AXIS_ACC_TLAST_EN
      frame_q = {3, 4};
      sendFrame(0, 1'b1);
      expectTotal(7, 0);
      frame_q = {1, 1, 1, 1};
      sendFrame(0, 1'b0);
      expectTotal(4, 0);
`endif

      for (int f = 0; f < 12; f++) begin
         frame_q.delete();
         len   = ACC_LEN;
         early = 1'b0;
`ifdef ADDER_AXIS_ACC_TLAST_EN
         len   = $urandom_range(ACC_LEN, 1);
         early = (len < ACC_LEN) || ($urandom_range(1, 0) == 1);
`endif
         for (int i = 0; i < len; i++) frame_q.push_back($urandom_range(255, 0));
         sendFrame(3, early);
         expectTotal(modelTotal(), $urandom_range(3, 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
